// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA raster timing generator and blanked RGB565 output stage.
// Emits pixel coordinates one cycle ahead of display to match a registered pixel source.
module vga_timing_ctrl #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 40,
  parameter int unsigned H_LEFT   = 8,
  parameter int unsigned H_VALID  = 640,
  parameter int unsigned H_RIGHT  = 8,
  parameter int unsigned H_FRONT  = 8,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 25,
  parameter int unsigned V_TOP    = 8,
  parameter int unsigned V_VALID  = 480,
  parameter int unsigned V_BOTTOM = 8,
  parameter int unsigned V_FRONT  = 2,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam int unsigned HSum  = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int unsigned VSum  = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int unsigned H_ACT = H_SYNC + H_BACK + H_LEFT;
  localparam int unsigned V_ACT = V_SYNC + V_BACK + V_TOP;

  localparam logic [9:0] HSyncEnd = 10'(H_SYNC);
  localparam logic [9:0] HActLo   = 10'(H_ACT);
  localparam logic [9:0] HActHi   = 10'(H_ACT + H_VALID);
  localparam logic [9:0] HReqLo   = 10'(H_ACT - 1);
  localparam logic [9:0] HReqHi   = 10'(H_ACT + H_VALID - 1);
  localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VSyncEnd = 10'(V_SYNC);
  localparam logic [9:0] VActLo   = 10'(V_ACT);
  localparam logic [9:0] VActHi   = 10'(V_ACT + V_VALID);
  localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);

  if ((HSum != H_TOTAL) || (VSum != V_TOTAL)) begin : g_bad_params
    $error("vga_timing_ctrl: H_TOTAL/V_TOTAL do not match the sum of their segments");
  end

  logic [9:0] cnt_h_q, cnt_h_d;
  logic [9:0] cnt_v_q, cnt_v_d;
  logic       frame_start_q, frame_start_d;
  logic       h_end, v_end;
  logic       h_act, v_act, h_req, pix_data_req;

  always_comb begin
    h_end         = (cnt_h_q == HLast);
    v_end         = (cnt_v_q == VLast);
    cnt_h_d       = h_end ? 10'd0 : cnt_h_q + 10'd1;
    cnt_v_d       = cnt_v_q;
    if (h_end) begin
      cnt_v_d = v_end ? 10'd0 : cnt_v_q + 10'd1;
    end
    // Asserted during the first cycle of the new frame, i.e. after both counters wrap.
    frame_start_d = h_end && v_end;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q       <= 10'd0;
      cnt_v_q       <= 10'd0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    hsync        = (cnt_h_q < HSyncEnd);
    vsync        = (cnt_v_q < VSyncEnd);
    h_act        = (cnt_h_q >= HActLo) && (cnt_h_q < HActHi);
    v_act        = (cnt_v_q >= VActLo) && (cnt_v_q < VActHi);
    // Request window leads the display window by one cycle.
    h_req        = (cnt_h_q >= HReqLo) && (cnt_h_q < HReqHi);
    rgb_valid    = h_act && v_act;
    pix_data_req = h_req && v_act;
    pix_x        = pix_data_req ? (cnt_h_q - HReqLo) : 10'h3FF;
    pix_y        = pix_data_req ? (cnt_v_q - VActLo) : 10'h3FF;
    rgb          = rgb_valid ? pix_data : 16'h0000;
  end

  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: full-size instance for line-level timing,
// reduced-size instance for frame-level timing within a short run.
module tb_vga_timing_ctrl;

  logic        vga_clk;
  logic        sys_rst_n;
  logic        ffff_mode;
  logic [15:0] stub_q;
  logic [15:0] pix_data;
  logic [9:0]  pix_x, pix_y;
  logic        hsync, vsync, rgb_valid, frame_start;
  logic [15:0] rgb;

  logic [9:0]  s_pix_x, s_pix_y;
  logic        s_hsync, s_vsync, s_rgb_valid, s_frame_start;
  logic [15:0] s_rgb;

  int total = 0;
  int bad   = 0;
  int pos   = 0;

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Pattern source model: registers {y[4:0], x[5:0], y[4:0]} from the requested coordinates.
  always @(posedge vga_clk) stub_q <= {pix_y[4:0], pix_x[5:0], pix_y[4:0]};
  assign pix_data = ffff_mode ? 16'hFFFF : stub_q;

  vga_timing_ctrl u_dut (
    .vga_clk     (vga_clk),
    .sys_rst_n   (sys_rst_n),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb_valid   (rgb_valid),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  // 18 x 11 raster: active window h 7..14, v 5..8; frame = 198 cycles.
  vga_timing_ctrl #(
    .H_SYNC(4), .H_BACK(2), .H_LEFT(1), .H_VALID(8), .H_RIGHT(1), .H_FRONT(2), .H_TOTAL(18),
    .V_SYNC(2), .V_BACK(2), .V_TOP(1), .V_VALID(4), .V_BOTTOM(1), .V_FRONT(1), .V_TOTAL(11)
  ) u_small (
    .vga_clk     (vga_clk),
    .sys_rst_n   (sys_rst_n),
    .pix_data    (16'hFFFF),
    .pix_x       (s_pix_x),
    .pix_y       (s_pix_y),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .rgb_valid   (s_rgb_valid),
    .rgb         (s_rgb),
    .frame_start (s_frame_start)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to t rising edges after reset release and sample 2 ns later.
  task automatic goto(input int t);
    if (t > pos) begin
      repeat (t - pos) @(posedge vga_clk);
      #2;
      pos = t;
    end
  endtask

  typedef struct {
    int          v;
    int          h;
    logic        hs;
    logic        vs;
    logic        val;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [15:0] rgb;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int hs_cnt;
    int ff_cnt;
    int fs_cnt;
    int sh, sv;
    logic        e_val;
    logic        e_req;
    logic [9:0]  e_px, e_py;

    vecs[0]  = '{0,   0,   1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[1]  = '{0,   95,  1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[2]  = '{0,   96,  1'b0, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[3]  = '{1,   0,   1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[4]  = '{2,   0,   1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[5]  = '{34,  143, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[6]  = '{34,  500, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[7]  = '{35,  142, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[8]  = '{35,  143, 1'b0, 1'b0, 1'b0, 10'd0,   10'd0,   16'h0000};
    vecs[9]  = '{35,  144, 1'b0, 1'b0, 1'b1, 10'd1,   10'd0,   16'h0000};
    vecs[10] = '{35,  300, 1'b0, 1'b0, 1'b1, 10'd157, 10'd0,   16'h0380};
    vecs[11] = '{36,  144, 1'b0, 1'b0, 1'b1, 10'd1,   10'd1,   16'h0801};
    vecs[12] = '{36,  200, 1'b0, 1'b0, 1'b1, 10'd57,  10'd1,   16'h0F01};
    vecs[13] = '{36,  782, 1'b0, 1'b0, 1'b1, 10'd639, 10'd1,   16'h0FC1};
    vecs[14] = '{36,  783, 1'b0, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 16'h0FE1};
    vecs[15] = '{36,  784, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};

    sys_rst_n = 1'b0;
    ffff_mode = 1'b0;
    #1;
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_valid", 32'(rgb_valid), 32'd0);
    chk("rst_pix_x", 32'(pix_x), 32'h3FF);
    chk("rst_pix_y", 32'(pix_y), 32'h3FF);
    chk("rst_fs", 32'(frame_start), 32'd0);
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    pos = 0;

    for (int i = 0; i < 16; i++) begin
      goto(vecs[i].v * 800 + vecs[i].h);
      chk($sformatf("v%0d_h%0d_hsync", vecs[i].v, vecs[i].h), 32'(hsync), 32'(vecs[i].hs));
      chk($sformatf("v%0d_h%0d_vsync", vecs[i].v, vecs[i].h), 32'(vsync), 32'(vecs[i].vs));
      chk($sformatf("v%0d_h%0d_valid", vecs[i].v, vecs[i].h), 32'(rgb_valid), 32'(vecs[i].val));
      chk($sformatf("v%0d_h%0d_pix_x", vecs[i].v, vecs[i].h), 32'(pix_x), 32'(vecs[i].px));
      chk($sformatf("v%0d_h%0d_pix_y", vecs[i].v, vecs[i].h), 32'(pix_y), 32'(vecs[i].py));
      chk($sformatf("v%0d_h%0d_rgb", vecs[i].v, vecs[i].h), 32'(rgb), 32'(vecs[i].rgb));
      chk($sformatf("v%0d_h%0d_fs", vecs[i].v, vecs[i].h), 32'(frame_start), 32'd0);
    end

    // Constant white source over line 37: exactly 640 displayed pixels, black elsewhere.
    ffff_mode = 1'b1;
    ff_cnt = 0;
    for (int h = 0; h < 800; h++) begin
      goto(37 * 800 + h);
      e_val = (h >= 144) && (h < 784);
      chk($sformatf("l37_h%0d_rgb", h), 32'(rgb), e_val ? 32'hFFFF : 32'h0);
      if (rgb == 16'hFFFF) ff_cnt++;
    end
    chk("l37_white_count", 32'(ff_cnt), 32'd640);

    // Asynchronous reset mid-line: outputs must drop to reset values without a clock edge.
    goto(38 * 800 + 400);
    chk("pre_rst_hsync", 32'(hsync), 32'd0);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_hsync", 32'(hsync), 32'd1);
    chk("mid_rst_vsync", 32'(vsync), 32'd1);
    chk("mid_rst_valid", 32'(rgb_valid), 32'd0);
    chk("mid_rst_pix_x", 32'(pix_x), 32'h3FF);
    chk("mid_rst_pix_y", 32'(pix_y), 32'h3FF);
    chk("mid_rst_rgb", 32'(rgb), 32'h0);
    chk("mid_rst_fs", 32'(frame_start), 32'd0);
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    pos = 0;

    hs_cnt = 0;
    ff_cnt = 0;
    fs_cnt = 0;
    for (int n = 0; n < 3 * 198 + 20; n++) begin
      goto(n);
      if (n < 800 && hsync) hs_cnt++;
      if (n < 200) begin
        chk($sformatf("post_rst_n%0d_hsync", n), 32'(hsync), 32'(n < 96));
        chk($sformatf("post_rst_n%0d_fs", n), 32'(frame_start), 32'd0);
      end
      sh    = n % 18;
      sv    = (n / 18) % 11;
      e_val = (sh >= 7) && (sh < 15) && (sv >= 5) && (sv < 9);
      e_req = (sh >= 6) && (sh < 14) && (sv >= 5) && (sv < 9);
      e_px  = e_req ? 10'(sh - 6) : 10'h3FF;
      e_py  = e_req ? 10'(sv - 5) : 10'h3FF;
      chk($sformatf("sm_n%0d_fs", n), 32'(s_frame_start), 32'((n > 0) && (n % 198 == 0)));
      chk($sformatf("sm_n%0d_hsync", n), 32'(s_hsync), 32'(sh < 4));
      chk($sformatf("sm_n%0d_vsync", n), 32'(s_vsync), 32'(sv < 2));
      chk($sformatf("sm_n%0d_valid", n), 32'(s_rgb_valid), 32'(e_val));
      chk($sformatf("sm_n%0d_rgb", n), 32'(s_rgb), e_val ? 32'hFFFF : 32'h0);
      chk($sformatf("sm_n%0d_pix_x", n), 32'(s_pix_x), 32'(e_px));
      chk($sformatf("sm_n%0d_pix_y", n), 32'(s_pix_y), 32'(e_py));
      if (s_frame_start) fs_cnt++;
      if (n < 198 && s_rgb == 16'hFFFF) ff_cnt++;
    end
    chk("post_rst_hsync_width", 32'(hs_cnt), 32'd96);
    chk("sm_frame_white_count", 32'(ff_cnt), 32'd32);
    chk("sm_frame_start_count", 32'(fs_cnt), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
